// File: rtl/k054539_core.sv
// Reduced 054539 PCM core: register file, 8-slot sample engine, stereo mixer and serial output.
// Optional build macro K054539_TIMER_EN adds the frame-rate down-counter timer on PIN_TIM.
module k054539_core #(
    parameter int FRAME_CLKS = 384,
    parameter int SLOT_CLKS  = 48
) (
    input  logic        CLK,
    input  logic        NRES,
    input  logic [7:0]  PIN_AB,
    input  logic        PIN_AB09,
    input  logic [7:0]  PIN_DB_IN,
    output logic [7:0]  PIN_DB_OUT,
    input  logic        NCS,
    input  logic        NRD,
    input  logic        NWR,
    output logic        PIN_WAIT,
    output logic        PIN_DTCK,
    output logic        PIN_WDCK,
    input  logic        PIN_DTS1,
    input  logic        PIN_DTS2,
    output logic [23:0] PIN_RA,
    input  logic [7:0]  PIN_RD_IN,
    output logic [7:0]  PIN_RD_OUT,
    output logic        PIN_TIM,
    input  logic        PIN_RRMD,
    output logic        PIN_DLY,
    input  logic        PIN_AXDA,
    input  logic        PIN_ALRA,
    input  logic        PIN_USE2
);
    localparam int BIT_CLKS = FRAME_CLKS / 32;
    localparam int HALF_BIT = BIT_CLKS / 2;

    logic [7:0]         regs [512];
    logic [2:0]         wsync;
    logic               wr_stb;
    logic [8:0]         host_addr;

    logic [8:0]         cnt;
    logic [2:0]         slot;
    logic [5:0]         off;
    logic               frame_end;

    logic [23:0]        pos [8];
    logic [15:0]        frac [8];
    logic [7:0]         active;
    logic [7:0]         rom_lat;
    logic signed [18:0] acc_l;
    logic signed [18:0] acc_r;

    logic [23:0]        pitch;
    logic [23:0]        loop_addr;
    logic [7:0]         vol;
    logic [1:0]         pan;
    logic               loop_en;
    logic               g_en;
    logic signed [16:0] prod;
    logic signed [18:0] contrib;
    logic [15:0]        sat_l;
    logic [15:0]        sat_r;

    logic [30:0]        shifter;
    logic [3:0]         ph;
    logic [4:0]         bitc;

    logic               unused_pins;

    assign unused_pins = PIN_DTS1 ^ PIN_DTS2 ^ PIN_RRMD ^ PIN_AXDA ^ PIN_ALRA ^ PIN_USE2;
    assign PIN_WAIT    = 1'b1;
    assign PIN_RD_OUT  = 8'h00;

    assign host_addr = {PIN_AB09, PIN_AB};
    assign wr_stb    = wsync[1] & ~wsync[2];
    assign frame_end = (cnt == 9'(FRAME_CLKS - 1));

    // Fields of the channel owning the current slot.
    assign pitch     = {regs[{1'b0, slot, 5'h02}], regs[{1'b0, slot, 5'h01}], regs[{1'b0, slot, 5'h00}]};
    assign loop_addr = {regs[{1'b0, slot, 5'h0A}], regs[{1'b0, slot, 5'h09}], regs[{1'b0, slot, 5'h08}]};
    assign vol       = regs[{1'b0, slot, 5'h03}];
    assign pan       = regs[{1'b0, slot, 5'h05}][1:0];
    assign loop_en   = regs[{1'b1, 4'b0000, slot, 1'b1}][0];
    assign g_en      = regs[9'h12F][0];

    assign prod    = $signed(rom_lat) * $signed({1'b0, vol});
    assign contrib = {{2{prod[16]}}, prod};

    function automatic logic [15:0] sat16(input logic signed [18:0] a);
        if (a > 19'sd32767)
            return 16'h7FFF;
        else if (a < -19'sd32768)
            return 16'h8000;
        else
            return a[15:0];
    endfunction

    assign sat_l = sat16(acc_l);
    assign sat_r = sat16(acc_r);

    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            wsync      <= 3'b000;
            PIN_DB_OUT <= 8'h00;
            for (int i = 0; i < 512; i++)
                regs[i] <= 8'h00;
        end else begin
            wsync <= {wsync[1:0], ~NCS & ~NWR};
            if (wr_stb)
                regs[host_addr] <= PIN_DB_IN;
            if (~NCS & ~NRD)
                PIN_DB_OUT <= (host_addr == 9'h12C) ? active : regs[host_addr];
            else
                PIN_DB_OUT <= 8'h00;
        end
    end

    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            cnt     <= '0;
            slot    <= '0;
            off     <= '0;
            PIN_RA  <= '0;
            rom_lat <= '0;
            acc_l   <= '0;
            acc_r   <= '0;
            active  <= '0;
            for (int i = 0; i < 8; i++) begin
                pos[i]  <= '0;
                frac[i] <= '0;
            end
        end else begin
            if (frame_end) begin
                cnt  <= '0;
                slot <= '0;
                off  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
                if (off == 6'(SLOT_CLKS - 1)) begin
                    off  <= '0;
                    slot <= slot + 1'b1;
                end else begin
                    off <= off + 1'b1;
                end
            end

            if (g_en && off == 6'd0)
                PIN_RA <= pos[slot];
            if (off == 6'd4)
                rom_lat <= PIN_RD_IN;

            if (frame_end) begin
                acc_l <= '0;
                acc_r <= '0;
            end else if (g_en && off == 6'd5 && active[slot]) begin
                if (rom_lat == 8'h80) begin
                    if (loop_en) begin
                        pos[slot]  <= loop_addr;
                        frac[slot] <= '0;
                    end else begin
                        active[slot] <= 1'b0;
                    end
                end else begin
                    if (pan != 2'b10)
                        acc_l <= acc_l + contrib;
                    if (pan != 2'b01)
                        acc_r <= acc_r + contrib;
                    {pos[slot], frac[slot]} <= {pos[slot], frac[slot]} + {16'd0, pitch};
                end
            end

            // Host key-on/off come last so they override an engine update in the same cycle.
            if (wr_stb && host_addr == 9'h114) begin
                for (int i = 0; i < 8; i++) begin
                    if (PIN_DB_IN[i]) begin
                        pos[i]    <= {regs[{1'b0, 3'(i), 5'h0E}], regs[{1'b0, 3'(i), 5'h0D}],
                                      regs[{1'b0, 3'(i), 5'h0C}]};
                        frac[i]   <= '0;
                        active[i] <= 1'b1;
                    end
                end
            end
            if (wr_stb && host_addr == 9'h115) begin
                for (int i = 0; i < 8; i++)
                    if (PIN_DB_IN[i])
                        active[i] <= 1'b0;
            end
        end
    end

    // The MSB of the left word goes straight to PIN_DLY at load; the shifter keeps the other 31 bits.
    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            shifter  <= '0;
            ph       <= '0;
            bitc     <= '0;
            PIN_DLY  <= 1'b0;
            PIN_DTCK <= 1'b0;
            PIN_WDCK <= 1'b0;
        end else if (frame_end) begin
            shifter  <= {sat_l[14:0], sat_r};
            ph       <= '0;
            bitc     <= '0;
            PIN_DLY  <= sat_l[15];
            PIN_DTCK <= 1'b0;
            PIN_WDCK <= 1'b1;
        end else if (ph == 4'(BIT_CLKS - 1)) begin
            shifter  <= {shifter[29:0], 1'b0};
            ph       <= '0;
            bitc     <= bitc + 1'b1;
            PIN_DLY  <= shifter[30];
            PIN_DTCK <= 1'b0;
            PIN_WDCK <= (bitc < 5'd15);
        end else begin
            ph       <= ph + 1'b1;
            PIN_DTCK <= (ph >= 4'(HALF_BIT - 1));
        end
    end

`ifdef K054539_TIMER_EN
    logic [7:0] tim_cnt;

    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            tim_cnt <= '0;
            PIN_TIM <= 1'b0;
        end else if (frame_end && regs[9'h12F][5]) begin
            if (tim_cnt <= 8'd1) begin
                tim_cnt <= regs[9'h127];
                PIN_TIM <= ~PIN_TIM;
            end else begin
                tim_cnt <= tim_cnt - 1'b1;
            end
        end
    end
`else
    assign PIN_TIM = 1'b0;
`endif

endmodule

// File: tb/tb_k054539_core.sv
// Directed bench for k054539_core: host access, sample fetch, mixing, saturation, serial frames, reset, timer.
module tb_k054539_core;
    logic        CLK = 1'b0;
    logic        NRES;
    logic [7:0]  PIN_AB;
    logic        PIN_AB09;
    logic [7:0]  PIN_DB_IN;
    logic [7:0]  PIN_DB_OUT;
    logic        NCS, NRD, NWR;
    logic        PIN_WAIT, PIN_DTCK, PIN_WDCK, PIN_DLY, PIN_TIM;
    logic [23:0] PIN_RA;
    logic [7:0]  rom_data;
    logic [7:0]  PIN_RD_OUT;

    logic [7:0]  rom_val;
    logic [23:0] end_addr;
    logic [8:0]  tb_cnt;
    int          n_chk = 0;
    int          n_pass = 0;
    int          wait_low = 0;

    logic [7:0]  rd_d;
    logic [15:0] fl, fr;
    logic [23:0] ra_s [7];
    logic [23:0] ra_a, ra_b;

    always #5 CLK = ~CLK;

    assign rom_data = (PIN_RA == end_addr) ? 8'h80 : rom_val;

    k054539_core dut (
        .CLK(CLK), .NRES(NRES), .PIN_AB(PIN_AB), .PIN_AB09(PIN_AB09),
        .PIN_DB_IN(PIN_DB_IN), .PIN_DB_OUT(PIN_DB_OUT), .NCS(NCS), .NRD(NRD), .NWR(NWR),
        .PIN_WAIT(PIN_WAIT), .PIN_DTCK(PIN_DTCK), .PIN_WDCK(PIN_WDCK),
        .PIN_DTS1(1'b0), .PIN_DTS2(1'b0), .PIN_RA(PIN_RA), .PIN_RD_IN(rom_data),
        .PIN_RD_OUT(PIN_RD_OUT), .PIN_TIM(PIN_TIM), .PIN_RRMD(1'b0), .PIN_DLY(PIN_DLY),
        .PIN_AXDA(1'b0), .PIN_ALRA(1'b0), .PIN_USE2(1'b0)
    );

    // Reference frame position: 0 at reset, 0..383 wrapping.
    always @(posedge CLK or negedge NRES) begin
        if (!NRES) tb_cnt <= 9'd0;
        else       tb_cnt <= (tb_cnt == 9'd383) ? 9'd0 : tb_cnt + 9'd1;
    end

    always @(negedge CLK) if (PIN_WAIT !== 1'b1) wait_low++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wr(input logic [9:0] a, input logic [7:0] d);
        @(negedge CLK);
        PIN_AB09 = a[9]; PIN_AB = a[7:0]; PIN_DB_IN = d;
        NCS = 1'b0; NWR = 1'b0;
        repeat (6) @(negedge CLK);
        NWR = 1'b1; NCS = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    task automatic rd(input logic [9:0] a, output logic [7:0] d);
        @(negedge CLK);
        PIN_AB09 = a[9]; PIN_AB = a[7:0];
        NCS = 1'b0; NRD = 1'b0;
        repeat (2) @(negedge CLK);
        d = PIN_DB_OUT;
        NCS = 1'b1; NRD = 1'b1;
    endtask

    task automatic wait_cnt(input int c);
        int k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (tb_cnt != 9'(c) && k < 800);
        if (tb_cnt != 9'(c)) chk("wait_cnt_timeout", 32'(tb_cnt), 32'(c));
    endtask

    task automatic skip2();
        wait_cnt(0);
        wait_cnt(0);
    endtask

    // Deserialise one frame: start at a WDCK rise, take PIN_DLY on each DTCK rise.
    task automatic get_frame(output logic [15:0] l, output logic [15:0] r);
        logic [31:0] sh = '0;
        int   n = 0;
        bit   found = 0;
        logic pw = PIN_WDCK;
        logic pd = 1'b0;
        for (int i = 0; i < 1200 && n < 32; i++) begin
            @(negedge CLK);
            if (!found) begin
                if (PIN_WDCK && !pw) begin
                    found = 1;
                    pd = PIN_DTCK;
                end
                pw = PIN_WDCK;
            end else begin
                if (PIN_DTCK && !pd) begin
                    sh = {sh[30:0], PIN_DLY};
                    n++;
                end
                pd = PIN_DTCK;
            end
        end
        chk("frame_bits", 32'(n), 32'd32);
        l = sh[31:16];
        r = sh[15:0];
    endtask

    task automatic wait_toggle(output int c);
        logic p = PIN_TIM;
        c = 0;
        do begin
            @(negedge CLK);
            c++;
        end while (PIN_TIM == p && c < 2000);
    endtask

    initial begin
        int t1, t2;
        NRES = 1'b0; NCS = 1'b1; NRD = 1'b1; NWR = 1'b1;
        PIN_AB = 8'h00; PIN_AB09 = 1'b0; PIN_DB_IN = 8'h00;
        rom_val = 8'h10; end_addr = 24'h000105;
        repeat (3) @(negedge CLK);
        chk("rst_db_out", 32'(PIN_DB_OUT), 32'h0);
        chk("rst_ra", 32'(PIN_RA), 32'h0);
        chk("rst_rd_out", 32'(PIN_RD_OUT), 32'h0);
        chk("rst_serial", {29'd0, PIN_DTCK, PIN_WDCK, PIN_DLY}, 32'h0);
        chk("rst_tim", 32'(PIN_TIM), 32'h0);
        chk("rst_wait", 32'(PIN_WAIT), 32'h1);
        NRES = 1'b1;

        wr(10'h050, 8'h11);
        wr(10'h051, 8'h22);
        wr(10'h210, 8'h55);
        rd(10'h050, rd_d); chk("rd_050", 32'(rd_d), 32'h11);
        rd(10'h051, rd_d); chk("rd_051", 32'(rd_d), 32'h22);
        rd(10'h210, rd_d); chk("rd_210", 32'(rd_d), 32'h55);
        rd(10'h010, rd_d); chk("rd_bank0_010", 32'(rd_d), 32'h00);

        // Channel 0: start 0x100, pitch 1.0, vol 0x40, pan both.
        wr(10'h00D, 8'h01);
        wr(10'h002, 8'h01);
        wr(10'h003, 8'h40);
        wr(10'h22F, 8'h01);
        wait_cnt(100);
        wr(10'h214, 8'h01);
        rd(10'h22C, rd_d); chk("mask_on", 32'(rd_d), 32'h01);
        for (int k = 0; k < 3; k++) begin
            wait_cnt(10);
            ra_s[k] = PIN_RA;
        end
        chk("ra_f1", 32'(ra_s[0]), 32'h100);
        chk("ra_f2", 32'(ra_s[1]), 32'h101);
        chk("ra_f3", 32'(ra_s[2]), 32'h102);
        get_frame(fl, fr);
        chk("mix_l", 32'(fl), 32'h0400);
        chk("mix_r", 32'(fr), 32'h0400);

        // End marker at 0x105 without loop.
        repeat (3) wait_cnt(0);
        rd(10'h22C, rd_d); chk("mask_end", 32'(rd_d), 32'h00);
        get_frame(fl, fr);
        chk("end_l", 32'(fl), 32'h0000);

        // Same marker with loop to 0x200.
        wr(10'h201, 8'h01);
        wr(10'h009, 8'h02);
        wait_cnt(100);
        wr(10'h214, 8'h01);
        for (int k = 0; k < 7; k++) begin
            wait_cnt(10);
            ra_s[k] = PIN_RA;
        end
        chk("loop_marker_fetch", 32'(ra_s[5]), 32'h105);
        chk("loop_fetch", 32'(ra_s[6]), 32'h200);
        rd(10'h22C, rd_d); chk("mask_loop", 32'(rd_d), 32'h01);

        // Two channels at full scale saturate.
        end_addr = 24'hFFFFFF;
        rom_val = 8'h7F;
        wr(10'h003, 8'hFF);
        wr(10'h02D, 8'h01);
        wr(10'h023, 8'hFF);
        wr(10'h214, 8'h02);
        skip2();
        get_frame(fl, fr);
        chk("satp_l", 32'(fl), 32'h7FFF);
        chk("satp_r", 32'(fr), 32'h7FFF);
        for (int n = 0; n < 8; n++) wr(10'(n * 32 + 5), 8'h01);
        skip2();
        get_frame(fl, fr);
        chk("panl_l", 32'(fl), 32'h7FFF);
        chk("panl_r", 32'(fr), 32'h0000);
        rom_val = 8'h81;
        skip2();
        get_frame(fl, fr);
        chk("satn_l", 32'(fl), 32'h8000);
        chk("satn_r", 32'(fr), 32'h0000);

        // Global disable: silence and frozen PIN_RA.
        wr(10'h22F, 8'h00);
        skip2();
        get_frame(fl, fr);
        chk("gdis_l", 32'(fl), 32'h0000);
        wait_cnt(10); ra_a = PIN_RA;
        wait_cnt(60); ra_b = PIN_RA;
        chk("gdis_ra_hold", 32'(ra_b), 32'(ra_a));
        rd(10'h003, rd_d); chk("gdis_host_rd", 32'(rd_d), 32'hFF);

        // Mid-frame reset.
        wr(10'h22F, 8'h01);
        wait_cnt(200);
        NRES = 1'b0;
        #1;
        chk("mrst_ra", 32'(PIN_RA), 32'h0);
        chk("mrst_serial", {29'd0, PIN_DTCK, PIN_WDCK, PIN_DLY}, 32'h0);
        chk("mrst_db_out", 32'(PIN_DB_OUT), 32'h0);
        chk("mrst_wait", 32'(PIN_WAIT), 32'h1);
        @(negedge CLK);
        NRES = 1'b1;
        rd(10'h003, rd_d); chk("mrst_reg", 32'(rd_d), 32'h00);
        rd(10'h22C, rd_d); chk("mrst_mask", 32'(rd_d), 32'h00);

        wr(10'h227, 8'h02);
        wr(10'h22F, 8'h21);
`ifdef K054539_TIMER_EN
        wait_toggle(t1);
        chk("tim_first", 32'(t1 < 2000), 32'h1);
        wait_toggle(t2);
        chk("tim_period", 32'(t2), 32'd768);
`else
        t1 = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge CLK);
            if (PIN_TIM !== 1'b0) t1++;
        end
        chk("tim_const0", 32'(t1), 32'd0);
        rd(10'h227, rd_d); chk("tim_reg_storage", 32'(rd_d), 32'h02);
`endif
        chk("wait_never_low", 32'(wait_low), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
